// File: rtl/sdram_arb_pkg.sv
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared types and constants for the SDRAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_arb_pkg;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        IDLE = 3'd1,
        CMD  = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OWN_RF  = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DMA = 2'd2
    } owner_t;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

    // Counter width for the default slot/refresh lengths (6 and 8)
    localparam int CW = cnt_width(6, 8);

endpackage

`default_nettype wire

// File: rtl/sdram_arb_if.sv
// ============================================================================
// Module      : sdram_arb_if
// Description : Requester (CPU, DMA, refresh) and controller signals of the
//               SDRAM arbiter; slave = arbiter side, master = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdram_arb_if #(
    parameter int AW = 24
);
    logic          sdrReady;
    logic          cpuRd;
    logic          cpuWr;
    logic [AW-1:0] cpuA;
    logic [7:0]    cpuD;
    logic [7:0]    cpuQ;
    logic          cpuBusy;
    logic          rfshReq;
    logic          dmaReq;
    logic          dmaWe;
    logic [AW-1:0] dmaA;
    logic [7:0]    dmaD;
    logic [7:0]    dmaQ;
    logic          dmaAck;
    logic          sdrRf;
    logic          sdrRd;
    logic          sdrWr;
    logic [AW-1:0] sdrA;
    logic [15:0]   sdrD;
    logic [15:0]   sdrQ;

    modport slave (
        input  sdrReady, cpuRd, cpuWr, cpuA, cpuD, rfshReq,
        input  dmaReq, dmaWe, dmaA, dmaD, sdrQ,
        output cpuQ, cpuBusy, dmaQ, dmaAck, sdrRf, sdrRd, sdrWr, sdrA, sdrD
    );

    modport master (
        output sdrReady, cpuRd, cpuWr, cpuA, cpuD, rfshReq,
        output dmaReq, dmaWe, dmaA, dmaD, sdrQ,
        input  cpuQ, cpuBusy, dmaQ, dmaAck, sdrRf, sdrRd, sdrWr, sdrA, sdrD
    );
endinterface

`default_nettype wire

// File: rtl/sdram_arb_edge.sv
// ============================================================================
// Module      : sdram_arb_edge
// Description : Rising-edge detector with a pending flag. o_take flags an
//               accepted edge; a clear and a new edge in one cycle keep the flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_arb_edge (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_sig,
    input  wire logic i_block,
    input  wire logic i_clr,
    output logic      o_take,
    output logic      o_pend
);
    logic r_prev;
    logic r_pend;
    logic w_rise;

    assign w_rise = i_sig & ~r_prev;
    assign o_take = w_rise & ~i_block & (~r_pend | i_clr);
    assign o_pend = r_pend;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_prev <= i_sig;
            r_pend <= (r_pend & ~i_clr) | o_take;
        end
    end
endmodule

`default_nettype wire

// File: rtl/sdram_arbiter.sv
// ============================================================================
// Module      : sdram_arbiter
// Description : One-command-per-slot arbiter (refresh > CPU > DMA) in front of
//               the SDRAM controller. Define SDRAM_ARB_RR_EN for CPU/DMA round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_arbiter #(
    parameter int AW          = 24,
    parameter int SLOT_CYCLES = 6,
    parameter int RFSH_CYCLES = 8
) (
    input  wire logic  clock,
    input  wire logic  reset,
    sdram_arb_if.slave bus
);
    import sdram_arb_pkg::*;

    localparam int             c_cw      = cnt_width(SLOT_CYCLES, RFSH_CYCLES);
    localparam logic [c_cw-1:0] c_slot_tc = c_cw'(SLOT_CYCLES - 1);
    localparam logic [c_cw-1:0] c_rfsh_tc = c_cw'(RFSH_CYCLES - 1);

    state_t          r_state, w_state_nx;
    owner_t          r_owner, w_winner;
    logic            w_grant, w_fin, r_is_wr;
    logic [c_cw-1:0] r_cnt, w_term;
    logic [AW-1:0]   r_cpu_a, r_sdr_a;
    logic [7:0]      r_cpu_d, r_cpu_q, r_dma_q;
    logic [15:0]     r_sdr_d;
    logic            r_sdr_rf, r_sdr_rd, r_sdr_wr, r_dma_ack;
    logic            w_rd_take, w_rd_pend, w_wr_take, w_wr_pend, w_rf_pend;
    logic            w_svc, w_cpu_svc, w_rf_svc, w_clr_cpu, w_clr_rf, w_cpu_pend;
    logic            w_unused_rf_take, w_unused_q;
`ifdef SDRAM_ARB_RR_EN
    logic            r_last_dma;
`endif

    assign w_svc      = (r_state == CMD) || (r_state == WAIT);
    assign w_cpu_svc  = w_svc && (r_owner == OWN_CPU);
    assign w_rf_svc   = w_svc && (r_owner == OWN_RF);
    assign w_clr_cpu  = (r_state == DONE) && (r_owner == OWN_CPU);
    assign w_clr_rf   = (r_state == DONE) && (r_owner == OWN_RF);
    assign w_cpu_pend = w_rd_pend | w_wr_pend;

    // A read edge coinciding with an accepted write edge is folded into the write
    sdram_arb_edge u_edge_rd (
        .clock(clock), .reset(reset), .i_sig(bus.cpuRd),
        .i_block(w_cpu_svc | (w_wr_pend & ~w_clr_cpu) | w_wr_take),
        .i_clr(w_clr_cpu), .o_take(w_rd_take), .o_pend(w_rd_pend)
    );

    sdram_arb_edge u_edge_wr (
        .clock(clock), .reset(reset), .i_sig(bus.cpuWr),
        .i_block(w_cpu_svc | (w_rd_pend & ~w_clr_cpu)),
        .i_clr(w_clr_cpu), .o_take(w_wr_take), .o_pend(w_wr_pend)
    );

    sdram_arb_edge u_edge_rf (
        .clock(clock), .reset(reset), .i_sig(bus.rfshReq),
        .i_block(w_rf_svc), .i_clr(w_clr_rf),
        .o_take(w_unused_rf_take), .o_pend(w_rf_pend)
    );

    always_comb begin
        w_state_nx = r_state;
        w_grant    = 1'b0;
        w_winner   = OWN_RF;
        w_fin      = 1'b0;
        w_term     = (r_owner == OWN_RF) ? c_rfsh_tc : c_slot_tc;
        case (r_state)
            INIT: if (bus.sdrReady) w_state_nx = IDLE;
            IDLE: begin
                if (!bus.sdrReady) begin
                    w_state_nx = INIT;
                end else if (w_rf_pend || w_cpu_pend || bus.dmaReq) begin
                    w_grant    = 1'b1;
                    w_state_nx = CMD;
                    if (w_rf_pend)
                        w_winner = OWN_RF;
                    else if (w_cpu_pend && bus.dmaReq)
`ifdef SDRAM_ARB_RR_EN
                        w_winner = r_last_dma ? OWN_CPU : OWN_DMA;
`else
                        w_winner = OWN_CPU;
`endif
                    else if (w_cpu_pend)
                        w_winner = OWN_CPU;
                    else
                        w_winner = OWN_DMA;
                end
            end
            CMD:  w_state_nx = WAIT;
            WAIT: begin
                if (r_cnt == w_term) begin
                    w_fin      = 1'b1;
                    w_state_nx = DONE;
                end
            end
            DONE:    w_state_nx = bus.sdrReady ? IDLE : INIT;
            default: w_state_nx = INIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= INIT;
        else        r_state <= w_state_nx;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_owner    <= OWN_RF;
            r_is_wr    <= 1'b0;
            r_cnt      <= '0;
            r_cpu_a    <= '0;
            r_cpu_d    <= '0;
            r_sdr_a    <= '0;
            r_sdr_d    <= '0;
            r_cpu_q    <= '0;
            r_dma_q    <= '0;
            r_sdr_rf   <= 1'b0;
            r_sdr_rd   <= 1'b0;
            r_sdr_wr   <= 1'b0;
            r_dma_ack  <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
            r_last_dma <= 1'b1;
`endif
        end else begin
            r_sdr_rf  <= w_grant && (w_winner == OWN_RF);
            r_sdr_rd  <= w_grant && (((w_winner == OWN_CPU) && !w_wr_pend) ||
                                     ((w_winner == OWN_DMA) && !bus.dmaWe));
            r_sdr_wr  <= w_grant && (((w_winner == OWN_CPU) && w_wr_pend) ||
                                     ((w_winner == OWN_DMA) && bus.dmaWe));
            r_dma_ack <= w_fin && (r_owner == OWN_DMA);
            if (w_rd_take || w_wr_take) begin
                r_cpu_a <= bus.cpuA;
                r_cpu_d <= bus.cpuD;
            end
            if (w_grant) begin
                r_owner <= w_winner;
                case (w_winner)
                    OWN_CPU: begin
                        r_sdr_a <= r_cpu_a;
                        r_sdr_d <= {2{r_cpu_d}};
                        r_is_wr <= w_wr_pend;
                    end
                    OWN_DMA: begin
                        r_sdr_a <= bus.dmaA;
                        r_sdr_d <= {2{bus.dmaD}};
                        r_is_wr <= bus.dmaWe;
                    end
                    default: begin
                        r_sdr_a <= '0;
                        r_sdr_d <= '0;
                        r_is_wr <= 1'b0;
                    end
                endcase
`ifdef SDRAM_ARB_RR_EN
                if (w_winner != OWN_RF) r_last_dma <= (w_winner == OWN_DMA);
`endif
            end
            if (r_state != WAIT)     r_cnt <= '0;
            else if (r_cnt != w_term) r_cnt <= r_cnt + 1'b1;
            // Read data is sampled on the last WAIT edge so it is valid during DONE
            if (w_fin && !r_is_wr) begin
                if (r_owner == OWN_CPU) r_cpu_q <= bus.sdrQ[7:0];
                if (r_owner == OWN_DMA) r_dma_q <= bus.sdrQ[7:0];
            end
        end
    end

    assign bus.sdrRf   = r_sdr_rf;
    assign bus.sdrRd   = r_sdr_rd;
    assign bus.sdrWr   = r_sdr_wr;
    assign bus.sdrA    = r_sdr_a;
    assign bus.sdrD    = r_sdr_d;
    assign bus.cpuQ    = r_cpu_q;
    assign bus.dmaQ    = r_dma_q;
    assign bus.dmaAck  = r_dma_ack;
    assign bus.cpuBusy = w_cpu_pend | w_cpu_svc;
    assign w_unused_q  = ^bus.sdrQ[15:8];
endmodule

`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Directed self-checking bench for sdram_arbiter (SLOT=6, RFSH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_arbiter;
    localparam int AW   = 24;
    localparam int SLOT = 6;
    localparam int RFSH = 8;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    sdram_arb_if #(.AW(AW)) bus ();

    sdram_arbiter #(.AW(AW), .SLOT_CYCLES(SLOT), .RFSH_CYCLES(RFSH)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic any_strobe();
        return bus.sdrRf | bus.sdrRd | bus.sdrWr;
    endfunction

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({bus.sdrRf, bus.sdrRd, bus.sdrWr, bus.dmaAck, bus.cpuBusy} !== 5'b0) begin
            errors++;
            $display("FAIL %s strobes: got %b expected 00000", name,
                     {bus.sdrRf, bus.sdrRd, bus.sdrWr, bus.dmaAck, bus.cpuBusy});
        end
        checks++;
        if (bus.sdrA !== 24'h0) begin
            errors++; $display("FAIL %s sdrA: got %h expected 000000", name, bus.sdrA);
        end
        checks++;
        if (bus.sdrD !== 16'h0) begin
            errors++; $display("FAIL %s sdrD: got %h expected 0000", name, bus.sdrD);
        end
        checks++;
        if (bus.cpuQ !== 8'h0) begin
            errors++; $display("FAIL %s cpuQ: got %h expected 00", name, bus.cpuQ);
        end
        checks++;
        if (bus.dmaQ !== 8'h0) begin
            errors++; $display("FAIL %s dmaQ: got %h expected 00", name, bus.dmaQ);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        check_outputs_zero("reset");
        reset = 1'b1;
    endtask

    task automatic test_init_hold();
        logic seen = 1'b0;
        bus.cpuA = 24'h000123;
        for (int i = 0; i < 20; i++) begin
            bus.cpuRd = ((i % 4) < 2);
            step();
            if (any_strobe()) seen = 1'b1;
        end
        bus.cpuRd = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL init_no_cmd: got strobe=%b expected 0", seen);
        end
        checks++;
        if (bus.cpuBusy !== 1'b1) begin
            errors++; $display("FAIL init_busy: got %b expected 1", bus.cpuBusy);
        end
        bus.sdrReady = 1'b1;
        step();
        checks++;
        if (any_strobe() !== 1'b0) begin
            errors++; $display("FAIL init_cmd_early: got strobe 1 expected 0");
        end
        step();
        checks++;
        if (bus.sdrRd !== 1'b1) begin
            errors++; $display("FAIL init_first_cmd: got sdrRd=%b expected 1", bus.sdrRd);
        end
        checks++;
        if (bus.sdrA !== 24'h000123) begin
            errors++; $display("FAIL init_addr: got %h expected 000123", bus.sdrA);
        end
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (bus.cpuBusy !== 1'b0) begin
            errors++; $display("FAIL init_drain: got cpuBusy=%b expected 0", bus.cpuBusy);
        end
    endtask

    task automatic test_cpu_read();
        int busy_cnt = 0;
        int rd_cnt   = 0;
        logic [23:0] a_seen = '0;
        bus.sdrQ  = 16'hA5A5;
        bus.cpuA  = 24'h004000;
        bus.cpuRd = 1'b1;
        step();
        do begin
            busy_cnt++;
            if (bus.sdrRd) begin
                rd_cnt++;
                a_seen = bus.sdrA;
            end
            if (busy_cnt == 1) bus.cpuRd = 1'b0;
            step();
        end while (bus.cpuBusy && busy_cnt < 40);
        checks++;
        if (busy_cnt != SLOT + 3) begin
            errors++; $display("FAIL cpu_busy_len: got %0d expected %0d", busy_cnt, SLOT + 3);
        end
        checks++;
        if (rd_cnt != 1) begin
            errors++; $display("FAIL cpu_rd_count: got %0d expected 1", rd_cnt);
        end
        checks++;
        if (a_seen !== 24'h004000) begin
            errors++; $display("FAIL cpu_rd_addr: got %h expected 004000", a_seen);
        end
        checks++;
        if (bus.cpuQ !== 8'hA5) begin
            errors++; $display("FAIL cpu_rd_data: got %h expected a5", bus.cpuQ);
        end
    endtask

    task automatic test_rfsh_then_wr();
        logic [2:0]  ev_k [2];
        int          ev_t [2];
        logic [15:0] ev_d [2];
        logic [23:0] ev_a [2];
        int          n_ev = 0;
        bus.sdrQ    = 16'h0000;
        bus.cpuA    = 24'h000077;
        bus.cpuD    = 8'h3C;
        bus.cpuWr   = 1'b1;
        bus.rfshReq = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            step();
            if (t == 2) begin
                bus.cpuWr   = 1'b0;
                bus.rfshReq = 1'b0;
            end
            if (any_strobe() && n_ev < 2) begin
                ev_k[n_ev] = {bus.sdrRf, bus.sdrRd, bus.sdrWr};
                ev_t[n_ev] = t;
                ev_d[n_ev] = bus.sdrD;
                ev_a[n_ev] = bus.sdrA;
                n_ev++;
            end
        end
        checks++;
        if (n_ev != 2) begin
            errors++; $display("FAIL rfwr_events: got %0d expected 2", n_ev);
        end else begin
            checks++;
            if (ev_k[0] !== 3'b100 || ev_t[0] != 2) begin
                errors++; $display("FAIL rfwr_first: got kind=%b t=%0d expected kind=100 t=2", ev_k[0], ev_t[0]);
            end
            checks++;
            if (ev_k[1] !== 3'b001 || ev_t[1] != 2 + RFSH + 3) begin
                errors++; $display("FAIL rfwr_second: got kind=%b t=%0d expected kind=001 t=%0d", ev_k[1], ev_t[1], 2 + RFSH + 3);
            end
            checks++;
            if (ev_d[1] !== 16'h3C3C) begin
                errors++; $display("FAIL rfwr_data: got %h expected 3c3c", ev_d[1]);
            end
            checks++;
            if (ev_a[1] !== 24'h000077) begin
                errors++; $display("FAIL rfwr_addr: got %h expected 000077", ev_a[1]);
            end
        end
    endtask

    task automatic test_dma_write();
        int wr_t [2];
        int ack_t [2];
        int n_wr = 0;
        int n_ack = 0;
        logic [23:0] a0 = '0;
        logic [15:0] d0 = '0;
        bus.dmaWe  = 1'b1;
        bus.dmaA   = 24'h123456;
        bus.dmaD   = 8'h77;
        bus.dmaReq = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            step();
            if (bus.sdrWr) begin
                if (n_wr == 0) begin a0 = bus.sdrA; d0 = bus.sdrD; end
                if (n_wr < 2) wr_t[n_wr] = t;
                n_wr++;
                if (n_wr == 2) bus.dmaReq = 1'b0;
            end
            if (bus.dmaAck) begin
                if (n_ack < 2) ack_t[n_ack] = t;
                n_ack++;
            end
        end
        checks++;
        if (n_wr != 2 || n_ack != 2) begin
            errors++; $display("FAIL dma_counts: got wr=%0d ack=%0d expected 2/2", n_wr, n_ack);
        end else begin
            checks++;
            if (wr_t[0] != 1) begin
                errors++; $display("FAIL dma_first_wr: got t=%0d expected 1", wr_t[0]);
            end
            checks++;
            if (ack_t[0] != SLOT + 2) begin
                errors++; $display("FAIL dma_ack_time: got t=%0d expected %0d", ack_t[0], SLOT + 2);
            end
            checks++;
            if (wr_t[1] != ack_t[0] + 2) begin
                errors++; $display("FAIL dma_b2b: got t=%0d expected %0d", wr_t[1], ack_t[0] + 2);
            end
            checks++;
            if (ack_t[1] != wr_t[1] + SLOT + 1) begin
                errors++; $display("FAIL dma_drop_ack: got t=%0d expected %0d", ack_t[1], wr_t[1] + SLOT + 1);
            end
        end
        checks++;
        if (a0 !== 24'h123456 || d0 !== 16'h7777) begin
            errors++; $display("FAIL dma_wr_bus: got a=%h d=%h expected 123456/7777", a0, d0);
        end
    endtask

    task automatic test_dma_read();
        int   n_rd = 0;
        logic got_ack = 1'b0;
        bus.dmaWe  = 1'b0;
        bus.dmaA   = 24'h000ABC;
        bus.sdrQ   = 16'h005A;
        bus.dmaReq = 1'b1;
        for (int t = 0; t < 20 && !got_ack; t++) begin
            step();
            if (bus.sdrRd) n_rd++;
            if (bus.dmaAck) begin
                got_ack = 1'b1;
                bus.dmaReq = 1'b0;
                checks++;
                if (bus.dmaQ !== 8'h5A) begin
                    errors++; $display("FAIL dma_rd_data: got %h expected 5a", bus.dmaQ);
                end
            end
        end
        checks++;
        if (!got_ack || n_rd != 1) begin
            errors++; $display("FAIL dma_rd_slot: got ack=%b rd=%0d expected 1/1", got_ack, n_rd);
        end
        bus.sdrQ = 16'h0000;
        step(); step();
        checks++;
        if (bus.dmaQ !== 8'h5A || bus.dmaAck !== 1'b0) begin
            errors++; $display("FAIL dma_rd_hold: got q=%h ack=%b expected 5a/0", bus.dmaQ, bus.dmaAck);
        end
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_dma_withdraw();
        int n_str = 0;
        int n_ack = 0;
        bus.dmaWe = 1'b1;
        bus.cpuRd = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            step();
            if (t == 1) bus.cpuRd = 1'b0;
            if (t == 3) bus.dmaReq = 1'b1;
            if (t == 5) bus.dmaReq = 1'b0;
            if (any_strobe()) n_str++;
            if (bus.dmaAck) n_ack++;
        end
        checks++;
        if (n_str != 1) begin
            errors++; $display("FAIL dma_withdraw_cmds: got %0d expected 1", n_str);
        end
        checks++;
        if (n_ack != 0) begin
            errors++; $display("FAIL dma_withdraw_ack: got %0d expected 0", n_ack);
        end
    endtask

    task automatic test_arbitration();
        logic [7:0] seq [10];
        int n_seq = 0;
        int n_ack = 0;
        int n_dma = 0;
        int t     = 0;
        int t_rd  = -100;
        bus.dmaWe = 1'b1;
        bus.dmaA  = 24'h000042;
        bus.dmaD  = 8'h11;
        bus.cpuA  = 24'h000200;
        bus.cpuRd = 1'b1;
        step();
        bus.dmaReq = 1'b1;
        while (n_seq < 10 && t < 150) begin
            step();
            t++;
            if (bus.sdrRd) begin
                seq[n_seq] = "C"; n_seq++;
                bus.cpuRd = 1'b0;
                t_rd = t;
            end else if (bus.sdrWr) begin
                seq[n_seq] = "D"; n_seq++; n_dma++;
            end
            if (bus.dmaAck) n_ack++;
            if (t == t_rd + 7) bus.cpuRd = 1'b1;
        end
        checks++;
        if (n_seq != 10) begin
            errors++; $display("FAIL arb_slots: got %0d expected 10", n_seq);
        end
`ifdef SDRAM_ARB_RR_EN
        checks++;
        if (seq[0] != "C" || seq[1] != "D" || seq[2] != "C") begin
            errors++; $display("FAIL arb_rr_order: got %c%c%c expected CDC", seq[0], seq[1], seq[2]);
        end
        checks++;
        if (n_dma != 5) begin
            errors++; $display("FAIL arb_rr_dma: got %0d expected 5", n_dma);
        end
`else
        checks++;
        if (n_ack != 0 || n_dma != 0) begin
            errors++; $display("FAIL arb_fixed_starve: got ack=%0d dma=%0d expected 0/0", n_ack, n_dma);
        end
`endif
        bus.cpuRd  = 1'b0;
        bus.dmaReq = 1'b0;
        for (int i = 0; i < 14; i++) step();
        checks++;
        if (bus.cpuBusy !== 1'b0) begin
            errors++; $display("FAIL arb_drain: got cpuBusy=%b expected 0", bus.cpuBusy);
        end
    endtask

    task automatic test_reset_mid_wait();
        int n_str = 0;
        bus.sdrQ  = 16'hA5A5;
        bus.cpuA  = 24'h004000;
        bus.cpuRd = 1'b1;
        step();
        bus.cpuRd = 1'b0;
        step(); step(); step();
        reset = 1'b0;
        #1;
        check_outputs_zero("reset_mid_wait");
        step();
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            if (any_strobe()) n_str++;
        end
        checks++;
        if (n_str != 0) begin
            errors++; $display("FAIL reset_stale_cmd: got %0d strobes expected 0", n_str);
        end
        checks++;
        if (bus.cpuBusy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", bus.cpuBusy);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        bus.sdrReady = 1'b0;
        bus.cpuRd    = 1'b0;
        bus.cpuWr    = 1'b0;
        bus.cpuA     = '0;
        bus.cpuD     = '0;
        bus.rfshReq  = 1'b0;
        bus.dmaReq   = 1'b0;
        bus.dmaWe    = 1'b0;
        bus.dmaA     = '0;
        bus.dmaD     = '0;
        bus.sdrQ     = '0;
        test_reset();
        test_init_hold();
        test_cpu_read();
        test_rfsh_then_wr();
        test_dma_write();
        test_dma_read();
        test_dma_withdraw();
        test_arbitration();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
